// File: rtl/pc_link_unit.sv
// Program-counter and link-writeback stage of the KGP-RISC core: next-PC select, $ra write, stall/halt.
// Optional return-address stack is built when the macro PC_LINK_RAS_EN is defined.
module pc_link_unit #(
  parameter int unsigned         PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [4:0]          LINK_REG  = 5'd31,
  parameter int unsigned         RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                instr_valid,
  input  logic                link_flag,
  input  logic                ret_flag,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic [PC_WIDTH-1:0] ra_in,
  input  logic                halt_req,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_valid,
  output logic                link_we,
  output logic [4:0]          link_waddr,
  output logic [PC_WIDTH-1:0] link_wdata,
  output logic                halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;

  logic                accept_c;
  logic [PC_WIDTH-1:0] seq_pc_c;
  logic [PC_WIDTH-1:0] target_aligned_c;
  logic [PC_WIDTH-1:0] ra_aligned_c;
  logic [PC_WIDTH-1:0] ret_pc_c;
  logic [PC_WIDTH-1:0] next_pc_c;

  assign link_waddr = LINK_REG;

  // An instruction retires only in RUN with valid decode and no stall.
  assign accept_c         = (state == RUN) && instr_valid && !stall;
  assign seq_pc_c         = pc + PC_WIDTH'(4);
  assign target_aligned_c = {branch_target[PC_WIDTH-1:2], 2'b00};
  assign ra_aligned_c     = {ra_in[PC_WIDTH-1:2], 2'b00};

`ifdef PC_LINK_RAS_EN
  localparam int unsigned RAS_IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned RAS_CW = $clog2(RAS_DEPTH + 1);

  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [RAS_IW-1:0]   ras_top;
  logic [RAS_CW-1:0]   ras_count;
  logic [RAS_IW-1:0]   ras_last_c;
  logic [RAS_IW-1:0]   ras_next_c;
  logic                ras_push_c;
  logic                ras_pop_c;

  // ras_top points at the next free slot; the newest entry sits just below it.
  assign ras_last_c = (ras_top == '0) ? RAS_IW'(RAS_DEPTH - 1) : ras_top - RAS_IW'(1);
  assign ras_next_c = (ras_top == RAS_IW'(RAS_DEPTH - 1)) ? '0 : ras_top + RAS_IW'(1);
  assign ras_push_c = accept_c && link_flag;
  assign ras_pop_c  = accept_c && !link_flag && ret_flag && (ras_count != '0);
  assign ret_pc_c   = (ras_count != '0) ? ras_mem[ras_last_c] : ra_aligned_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_top   <= '0;
      ras_count <= '0;
    end else if (ras_push_c) begin
      // A full stack overwrites the oldest entry, which is the slot at ras_top.
      ras_mem[ras_top] <= seq_pc_c;
      ras_top          <= ras_next_c;
      if (ras_count != RAS_CW'(RAS_DEPTH)) begin
        ras_count <= ras_count + RAS_CW'(1);
      end
    end else if (ras_pop_c) begin
      ras_top   <= ras_last_c;
      ras_count <= ras_count - RAS_CW'(1);
    end
  end
`else
  assign ret_pc_c = ra_aligned_c;
`endif

  // Next-PC priority: branch-and-link, return, taken branch, sequential.
  always_comb begin
    next_pc_c = seq_pc_c;
    if (link_flag) begin
      next_pc_c = target_aligned_c;
    end else if (ret_flag) begin
      next_pc_c = ret_pc_c;
    end else if (branch_taken) begin
      next_pc_c = target_aligned_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      link_we     <= 1'b0;
      link_wdata  <= '0;
      halted      <= 1'b0;
    end else begin
      link_we <= 1'b0;
      case (state)
        BOOT: begin
          if (halt_req) begin
            state       <= HALT;
            fetch_valid <= 1'b0;
            halted      <= 1'b1;
          end else begin
            state       <= RUN;
            fetch_valid <= 1'b1;
          end
        end
        RUN: begin
          if (accept_c) begin
            pc <= next_pc_c;
            if (link_flag) begin
              link_we    <= 1'b1;
              link_wdata <= seq_pc_c;
            end
          end
          // The accepted instruction (if any) still completes before halting.
          if (halt_req) begin
            state       <= HALT;
            fetch_valid <= 1'b0;
            halted      <= 1'b1;
          end
        end
        HALT: begin
          fetch_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_link_unit.sv
// Directed self-checking bench for pc_link_unit; expectations follow PC_LINK_RAS_EN when defined.
module tb_pc_link_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        instr_valid;
  logic        link_flag;
  logic        ret_flag;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] ra_in;
  logic        halt_req;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        link_we;
  logic [4:0]  link_waddr;
  logic [31:0] link_wdata;
  logic        halted;

  int n_checks = 0;
  int n_pass   = 0;

  pc_link_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .instr_valid  (instr_valid),
    .link_flag    (link_flag),
    .ret_flag     (ret_flag),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .ra_in        (ra_in),
    .halt_req     (halt_req),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .link_we      (link_we),
    .link_waddr   (link_waddr),
    .link_wdata   (link_wdata),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; instr_valid = 1'b0; link_flag = 1'b0; ret_flag = 1'b0;
    branch_taken = 1'b0; branch_target = '0; ra_in = '0; halt_req = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] e_pc, input logic e_we,
                           input logic e_fv, input logic e_halt);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".link_we"}, 32'(link_we), 32'(e_we));
    check({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(e_fv));
    check({tag, ".halted"}, 32'(halted), 32'(e_halt));
  endtask

  initial begin
    logic [31:0] exp_ret;
    idle_inputs();
    rst = 1'b1;
    step(); step();
    check_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    check("reset.link_wdata", link_wdata, 32'h0);
    check("reset.link_waddr", 32'(link_waddr), 32'd31);

    // BOOT -> RUN with pc unchanged
    rst = 1'b0;
    step();
    check_out("boot", 32'h0, 1'b0, 1'b1, 1'b0);

    instr_valid = 1'b1;
    step(); check("seq1.pc", pc, 32'h4);
    step(); check("seq2.pc", pc, 32'h8);
    step(); check("seq3.pc", pc, 32'hC);

    branch_taken = 1'b1; branch_target = 32'h40;
    step(); check_out("br40", 32'h40, 1'b0, 1'b1, 1'b0);

    branch_taken = 1'b0; link_flag = 1'b1; branch_target = 32'h100;
    step();
    check_out("bl100", 32'h100, 1'b1, 1'b1, 1'b0);
    check("bl100.wdata", link_wdata, 32'h44);
    check("bl100.waddr", 32'(link_waddr), 32'd31);

    link_flag = 1'b0;
    step(); check_out("after_bl", 32'h104, 1'b0, 1'b1, 1'b0);

    // Return with unaligned ra; stack (if built) also holds 0x44
    ret_flag = 1'b1; ra_in = 32'h47;
    step(); check("ret47.pc", pc, 32'h44);

    ret_flag = 1'b0; link_flag = 1'b1; branch_target = 32'h300;
    step();
    check("bl300.pc", pc, 32'h300);
    check("bl300.wdata", link_wdata, 32'h48);

    link_flag = 1'b0; ret_flag = 1'b1; ra_in = 32'h0;
`ifdef PC_LINK_RAS_EN
    exp_ret = 32'h48;
`else
    exp_ret = 32'h0;
`endif
    step(); check("ret_ras.pc", pc, exp_ret);

    ra_in = 32'h88;
    step(); check("ret_empty.pc", pc, 32'h88);

    ret_flag = 1'b0; branch_taken = 1'b1; branch_target = 32'h123;
    step(); check("br_align.pc", pc, 32'h120);

    branch_target = 32'hFFFF_FFFC;
    step(); check("br_top.pc", pc, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    step(); check("wrap.pc", pc, 32'h0);

    link_flag = 1'b1; ret_flag = 1'b1; ra_in = 32'h80; branch_target = 32'h200;
    step();
    check_out("bl_ret", 32'h200, 1'b1, 1'b1, 1'b0);
    check("bl_ret.wdata", link_wdata, 32'h4);

    // Back-to-back bl
    ret_flag = 1'b0; branch_target = 32'h300;
    step();
    check("b2b1.we", 32'(link_we), 32'd1);
    check("b2b1.wdata", link_wdata, 32'h204);
    branch_target = 32'h400;
    step();
    check("b2b2.we", 32'(link_we), 32'd1);
    check("b2b2.wdata", link_wdata, 32'h304);
    check("b2b2.pc", pc, 32'h400);

    instr_valid = 1'b0;
    step(); check_out("novalid", 32'h400, 1'b0, 1'b1, 1'b0);

    // Stalled bl is held, then taken once
    instr_valid = 1'b1; stall = 1'b1; branch_target = 32'h500;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("stall%0d", i), 32'h400, 1'b0, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step();
    check_out("unstall", 32'h500, 1'b1, 1'b1, 1'b0);
    check("unstall.wdata", link_wdata, 32'h404);
    link_flag = 1'b0; instr_valid = 1'b0;
    step(); check("unstall_end.we", 32'(link_we), 32'd0);

    // bl with halt completes, then halts
    instr_valid = 1'b1; link_flag = 1'b1; branch_target = 32'h600; halt_req = 1'b1;
    step();
    check_out("bl_halt", 32'h600, 1'b1, 1'b0, 1'b1);
    check("bl_halt.wdata", link_wdata, 32'h504);
    link_flag = 1'b0; halt_req = 1'b0;
    step(); check_out("halt1", 32'h600, 1'b0, 1'b0, 1'b1);
    branch_taken = 1'b1; branch_target = 32'h700;
    step(); check_out("halt2", 32'h600, 1'b0, 1'b0, 1'b1);

    idle_inputs();
    rst = 1'b1;
    step();
    check_out("rst_halt", 32'h0, 1'b0, 1'b0, 1'b0);
    check("rst_halt.wdata", link_wdata, 32'h0);

    // halt_req during BOOT skips RUN
    rst = 1'b0; halt_req = 1'b1;
    step(); check_out("boot_halt", 32'h0, 1'b0, 1'b0, 1'b1);
    halt_req = 1'b0; instr_valid = 1'b1;
    step(); check_out("boot_halt2", 32'h0, 1'b0, 1'b0, 1'b1);

    // halt_req while not accepting: halt with pc unchanged
    rst = 1'b1; instr_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    instr_valid = 1'b1;
    step(); check("pre_halt.pc", pc, 32'h4);
    stall = 1'b1; halt_req = 1'b1;
    step(); check_out("stall_halt", 32'h4, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
